// File: rtl/vector_types_pkg.sv
// Shared types and helpers for the vector element sequencer slice.
package vector_types_pkg;

  localparam int unsigned VSEQ_VLEN     = 128;
  localparam int unsigned VSEQ_MAX_LMUL = 8;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_t;

  typedef enum logic {
    VSEQ_IDLE = 1'b0,
    VSEQ_RUN  = 1'b1
  } vseq_state_t;

  // log2(elements per register) for a given element width: log2(VLEN) - 3 - eew
  function automatic logic [4:0] elem_shift(input logic [1:0] eew,
                                            input int unsigned vlen_log2 = $clog2(VSEQ_VLEN));
    return 5'(vlen_log2 - 32'd3 - 32'(eew));
  endfunction

endpackage

// File: rtl/vseq_offset_calc.sv
// Combinational beat decode: element index -> register/element offset, lane mask, last flag.
module vseq_offset_calc
  import vector_types_pkg::*;
#(
  parameter int unsigned VLEN      = VSEQ_VLEN,
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned VL_WIDTH  = 8
) (
  input  logic                 i_valid,
  input  logic [VL_WIDTH-1:0]  i_idx,
  input  logic [VL_WIDTH-1:0]  i_vl,
  input  sew_t                 i_eew,
  output logic [2:0]           o_reg_offset,
  output logic [3:0]           o_elem_offset,
  output logic [NUM_LANES-1:0] o_lane_mask,
  output logic                 o_last
);

  localparam int unsigned VLEN_LOG2 = $clog2(VLEN);

  logic [4:0]          w_shift;
  logic [VL_WIDTH-1:0] w_elem_mask;
  logic [VL_WIDTH:0]   w_lane_idx;

  always_comb begin
    w_shift       = elem_shift(i_eew, VLEN_LOG2);
    w_elem_mask   = (VL_WIDTH'(1) << w_shift) - VL_WIDTH'(1);
    w_lane_idx    = '0;
    o_reg_offset  = '0;
    o_elem_offset = '0;
    o_lane_mask   = '0;
    o_last        = 1'b0;
    // Outputs are forced to zero outside a valid beat so idle state reads clean.
    if (i_valid) begin
      o_reg_offset  = 3'(i_idx >> w_shift);
      o_elem_offset = 4'(i_idx & w_elem_mask);
      o_last        = ({1'b0, i_idx} + (VL_WIDTH + 1)'(NUM_LANES)) >= {1'b0, i_vl};
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        w_lane_idx     = {1'b0, i_idx} + (VL_WIDTH + 1)'(i);
        o_lane_mask[i] = w_lane_idx < {1'b0, i_vl};
      end
    end
  end

endmodule

// File: rtl/vector_element_sequencer.sv
// Issues NUM_LANES-wide element beats for one decoded vector instruction at a time.
module vector_element_sequencer
  import vector_types_pkg::*;
#(
  parameter int unsigned VLEN      = VSEQ_VLEN,
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned VL_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [VL_WIDTH-1:0]  vl,
  input  logic [VL_WIDTH-1:0]  vstart,
  input  logic [1:0]           sew,
  input  logic                 vd_widen,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [VL_WIDTH-1:0]  out_elem_idx,
  output logic [NUM_LANES-1:0] out_lane_mask,
  output logic [2:0]           out_reg_offset,
  output logic [3:0]           out_elem_offset,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  vseq_state_t         r_state;
  logic [VL_WIDTH-1:0] r_idx;
  logic [VL_WIDTH-1:0] r_vl;
  sew_t                r_eew;
  logic                r_first;
  logic                r_done;

  logic w_run;
  logic w_last;
  logic w_retire;
  logic w_accept;
  sew_t w_eew;

  assign w_run    = (r_state == VSEQ_RUN);
  assign w_retire = w_run && !stall;
  assign in_ready = !w_run || (w_last && !stall && !flush);
  assign w_accept = in_valid && in_ready;

  // Widening saturates at 64-bit; decode flags the illegal widen-from-64 case.
  always_comb begin
    w_eew = sew_t'(sew);
    if (vd_widen && (sew != 2'd3)) begin
      w_eew = sew_t'(sew + 2'd1);
    end
  end

  vseq_offset_calc #(
    .VLEN      (VLEN),
    .NUM_LANES (NUM_LANES),
    .VL_WIDTH  (VL_WIDTH)
  ) u_offset_calc (
    .i_valid       (w_run),
    .i_idx         (r_idx),
    .i_vl          (r_vl),
    .i_eew         (r_eew),
    .o_reg_offset  (out_reg_offset),
    .o_elem_offset (out_elem_offset),
    .o_lane_mask   (out_lane_mask),
    .o_last        (w_last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= VSEQ_IDLE;
      r_idx   <= '0;
      r_vl    <= '0;
      r_eew   <= SEW_8;
      r_first <= 1'b0;
      r_done  <= 1'b0;
    end else if (flush) begin
      r_state <= VSEQ_IDLE;
      r_first <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_retire) begin
        r_first <= 1'b0;
        if (w_last) begin
          r_state <= VSEQ_IDLE;
          r_done  <= 1'b1;
        end else begin
          r_idx <= r_idx + VL_WIDTH'(NUM_LANES);
        end
      end
      // An accept on the retiring edge overrides the return to idle above.
      if (w_accept) begin
        if (vstart < vl) begin
          r_state <= VSEQ_RUN;
          r_idx   <= vstart;
          r_vl    <= vl;
          r_eew   <= w_eew;
          r_first <= 1'b1;
        end else begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign out_valid    = w_run;
  assign busy         = w_run;
  assign out_elem_idx = w_run ? r_idx : '0;
  assign out_first    = r_first;
  assign out_last     = w_last;
  assign done         = r_done;

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Self-checking bench: queue-based beat model checked every cycle plus literal expectations.
module tb_vector_element_sequencer;

  localparam int NL = 2;
  localparam int VW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] vl;
  logic [VW-1:0] vstart;
  logic [1:0]    sew;
  logic          vd_widen;
  logic          stall;
  logic          flush;
  logic          out_valid;
  logic [VW-1:0] out_elem_idx;
  logic [NL-1:0] out_lane_mask;
  logic [2:0]    out_reg_offset;
  logic [3:0]    out_elem_offset;
  logic          out_first;
  logic          out_last;
  logic          busy;
  logic          done;

  vector_element_sequencer #(
    .VLEN      (128),
    .NUM_LANES (NL),
    .VL_WIDTH  (VW)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .vl              (vl),
    .vstart          (vstart),
    .sew             (sew),
    .vd_widen        (vd_widen),
    .stall           (stall),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_elem_idx    (out_elem_idx),
    .out_lane_mask   (out_lane_mask),
    .out_reg_offset  (out_reg_offset),
    .out_elem_offset (out_elem_offset),
    .out_first       (out_first),
    .out_last        (out_last),
    .busy            (busy),
    .done            (done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int idx;
    int mask;
    int roff;
    int eoff;
    int first;
    int last;
  } beat_t;

  beat_t q[$];
  beat_t gq[$];
  beat_t log_b[$];
  int    checks = 0;
  int    passes = 0;
  bit    exp_done = 1'b0;
  bit    acc_seen = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Expected beats straight from the element-count rules.
  function automatic void gen(input int l, input int vs, input int sw, input int wd);
    int eew, epr;
    beat_t b;
    gq.delete();
    eew = wd ? ((sw + 1 > 3) ? 3 : sw + 1) : sw;
    epr = 128 / (8 << eew);
    for (int i = vs; i < l; i += NL) begin
      b.idx  = i;
      b.mask = 0;
      for (int k = 0; k < NL; k++) if (i + k < l) b.mask |= (1 << k);
      b.roff  = i / epr;
      b.eoff  = i % epr;
      b.first = (i == vs);
      b.last  = (i + NL >= l);
      gq.push_back(b);
    end
  endfunction

  bit    rdy, nd;
  beat_t ob;

  always @(negedge CLK) begin
    if (RST) begin
      q.delete();
      exp_done = 1'b0;
    end else begin
      rdy = (q.size() == 0);
      if (q.size() != 0) rdy = (q[0].last != 0) && !stall && !flush;
      chk("out_valid", out_valid, q.size() != 0);
      chk("busy", busy, q.size() != 0);
      chk("in_ready", in_ready, rdy);
      chk("done", done, exp_done);
      if (q.size() != 0) begin
        chk("elem_idx", out_elem_idx, q[0].idx);
        chk("lane_mask", out_lane_mask, q[0].mask);
        chk("reg_offset", out_reg_offset, q[0].roff);
        chk("elem_offset", out_elem_offset, q[0].eoff);
        chk("first", out_first, q[0].first);
        chk("last", out_last, q[0].last);
      end
      nd = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && !stall) begin
          ob.idx = out_elem_idx; ob.mask = out_lane_mask; ob.roff = out_reg_offset;
          ob.eoff = out_elem_offset; ob.first = out_first; ob.last = out_last;
          log_b.push_back(ob);
          if (q[0].last != 0) nd = 1'b1;
          void'(q.pop_front());
        end
        if (in_valid && rdy) begin
          acc_seen = 1'b1;
          if (vstart < vl) begin
            gen(vl, vstart, sew, vd_widen);
            foreach (gq[i]) q.push_back(gq[i]);
          end else begin
            nd = 1'b1;
          end
        end
      end
      exp_done = nd;
    end
  end

  // Called at posedge+2; returns at posedge+2 of the accepting edge.
  task automatic issue(input int l, input int vs, input int sw, input int wd);
    vl = VW'(l); vstart = VW'(vs); sew = 2'(sw); vd_widen = wd[0];
    acc_seen = 1'b0;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !acc_seen; n++) @(posedge CLK);
    if (!acc_seen) chk("accept_timeout", 0, 1);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200 && q.size() != 0; n++) begin
      @(posedge CLK); #2;
    end
    if (q.size() != 0) chk("idle_timeout", 0, 1);
    @(posedge CLK); #2;
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; vl = '0; vstart = '0; sew = '0;
    vd_widen = 1'b0; stall = 1'b0; flush = 1'b0;

    // Model pinned against hand-computed beats for vl=5, sew=32.
    gen(5, 0, 2, 0);
    chk("model_beats", gq.size(), 3);
    chk("model_idx2", gq[2].idx, 4);
    chk("model_mask2", gq[2].mask, 1);
    chk("model_roff2", gq[2].roff, 1);
    chk("model_eoff1", gq[1].eoff, 2);

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_first", out_first, 0);
    chk("rst_last", out_last, 0);
    chk("rst_mask", out_lane_mask, 0);
    chk("rst_idx", out_elem_idx, 0);
    chk("rst_roff", out_reg_offset, 0);
    chk("rst_eoff", out_elem_offset, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge CLK); #2;
    RST = 1'b0;
    @(posedge CLK); #2;

    // vl=5 sew=32: idx 0/2/4, masks 11/11/01, reg 0/0/1, elem 0/2/0
    log_b.delete();
    issue(5, 0, 2, 0);
    wait_idle();
    chk("t1_beats", log_b.size(), 3);
    if (log_b.size() == 3) begin
      chk("t1_idx0", log_b[0].idx, 0);  chk("t1_idx1", log_b[1].idx, 2);  chk("t1_idx2", log_b[2].idx, 4);
      chk("t1_mask0", log_b[0].mask, 3); chk("t1_mask1", log_b[1].mask, 3); chk("t1_mask2", log_b[2].mask, 1);
      chk("t1_roff1", log_b[1].roff, 0); chk("t1_roff2", log_b[2].roff, 1);
      chk("t1_eoff1", log_b[1].eoff, 2); chk("t1_eoff2", log_b[2].eoff, 0);
      chk("t1_last2", log_b[2].last, 1);
    end

    // Same instruction, 3-cycle stall on beat 2
    log_b.delete();
    issue(5, 0, 2, 0);
    @(posedge CLK); #2;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      chk("stall_idx", out_elem_idx, 2);
      chk("stall_valid", out_valid, 1);
    end
    @(posedge CLK); #2;
    stall = 1'b0;
    wait_idle();
    chk("stall_beats", log_b.size(), 3);

    // Zero-length instructions
    log_b.delete();
    issue(0, 0, 0, 0);
    chk("zl_done", done, 1);
    chk("zl_valid", out_valid, 0);
    wait_idle();
    issue(6, 6, 0, 0);
    chk("zl2_done", done, 1);
    wait_idle();
    chk("zl_beats", log_b.size(), 0);

    // Unaligned vstart: idx 3/5/7
    log_b.delete();
    issue(8, 3, 0, 0);
    wait_idle();
    chk("t4_beats", log_b.size(), 3);
    if (log_b.size() == 3) begin
      chk("t4_idx0", log_b[0].idx, 3); chk("t4_idx2", log_b[2].idx, 7);
      chk("t4_mask1", log_b[1].mask, 3); chk("t4_mask2", log_b[2].mask, 1);
      chk("t4_roff2", log_b[2].roff, 0); chk("t4_eoff2", log_b[2].eoff, 7);
    end

    // Flush on beat 2 of vl=16
    issue(16, 0, 0, 0);
    @(posedge CLK); #2;
    flush = 1'b1;
    @(posedge CLK); #2;
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_done", done, 0);
    wait_idle();

    // Back-to-back: vl=4 then widened vl=2 (eew=32)
    log_b.delete();
    issue(4, 0, 0, 0);
    issue(2, 0, 1, 1);
    wait_idle();
    chk("b2b_beats", log_b.size(), 3);
    if (log_b.size() == 3) begin
      chk("b2b_idx", log_b[2].idx, 0);
      chk("b2b_mask", log_b[2].mask, 3);
      chk("b2b_eoff", log_b[2].eoff, 0);
      chk("b2b_first", log_b[2].first, 1);
      chk("b2b_last", log_b[2].last, 1);
    end

    // Asynchronous reset mid-instruction
    issue(16, 0, 3, 0);
    @(posedge CLK); #2;
    RST = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mask", out_lane_mask, 0);
    chk("arst_idx", out_elem_idx, 0);
    chk("arst_first", out_first, 0);
    @(posedge CLK); #2;
    RST = 1'b0;
    @(posedge CLK); #2;
    chk("arst_ready", in_ready, 1);
    repeat (3) @(posedge CLK);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
